// File: rtl/rr_sel_arb.sv
// Two-channel round-robin arbiter that drives the select of a 2:1 mux, with a per-channel hold limit.
// Optional feature: define SEL_LOCK_EN to add a lock input that pins the current grant past hold expiry.
module rr_sel_arb #(
  parameter int HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_a,
  input  logic       req_b,
`ifdef SEL_LOCK_EN
  input  logic       lock,
`endif
  output logic       s,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       busy,
  output logic [1:0] dbg_state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_A = 2'd1;
  localparam logic [1:0] GNT_B = 2'd2;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

  logic [1:0] state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       last_b;
  logic       lock_i;

`ifdef SEL_LOCK_EN
  assign lock_i = lock;
`else
  assign lock_i = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req_a && req_b)  state_nxt = last_b ? GNT_A : GNT_B;
        else if (req_a)      state_nxt = GNT_A;
        else if (req_b)      state_nxt = GNT_B;
      end
      GNT_A: begin
        if (!req_a) begin
          state_nxt = req_b ? GNT_B : IDLE;
        end else if (cnt == HOLD_LAST) begin
          // Under lock the counter stays saturated so release happens right after lock falls.
          if (req_b && !lock_i) state_nxt = GNT_B;
          else if (!lock_i)     cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      GNT_B: begin
        if (!req_b) begin
          state_nxt = req_a ? GNT_A : IDLE;
        end else if (cnt == HOLD_LAST) begin
          if (req_a && !lock_i) state_nxt = GNT_A;
          else if (!lock_i)     cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Every entry into a grant state starts a fresh hold window.
    if (state_nxt != state && state_nxt != IDLE) cnt_nxt = 4'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      last_b <= 1'b1;
      s      <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state_nxt != state) begin
        if (state_nxt == GNT_A) last_b <= 1'b0;
        if (state_nxt == GNT_B) last_b <= 1'b1;
      end
      if (state_nxt == GNT_A) s <= 1'b0;
      if (state_nxt == GNT_B) s <= 1'b1;
    end
  end

  // Outputs decode straight from the state register; the reset clears them asynchronously.
  assign gnt_a     = (state == GNT_A);
  assign gnt_b     = (state == GNT_B);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_rr_sel_arb.sv
// Directed scoreboard bench for rr_sel_arb with HOLD=4; outputs packed as {busy, s, gnt_b, gnt_a}.
module tb_rr_sel_arb;

  logic       clk;
  logic       rst_n;
  logic       req_a;
  logic       req_b;
  logic       lock;
  logic       s, gnt_a, gnt_b, busy;
  logic [1:0] dbg_state;

  int n_checks;
  int n_fails;

  logic [3:0] exp_q[$];

  localparam logic [3:0] O_IDLE_S0 = 4'b0000;
  localparam logic [3:0] O_IDLE_S1 = 4'b0100;
  localparam logic [3:0] O_A       = 4'b1001;
  localparam logic [3:0] O_B       = 4'b1110;

  rr_sel_arb #(.HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_a     (req_a),
    .req_b     (req_b),
`ifdef SEL_LOCK_EN
    .lock      (lock),
`endif
    .s         (s),
    .gnt_a     (gnt_a),
    .gnt_b     (gnt_b),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] outs();
    return {busy, s, gnt_b, gnt_a};
  endfunction

  // Driver: apply requests, queue the expected post-edge outputs, compare after the edge.
  task automatic step(input string tag, input logic ra, input logic rb, input logic [3:0] exp);
    logic [3:0] e;
    req_a = ra;
    req_b = rb;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_q_empty"}, 4'd1, 4'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, outs(), e);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_n = 1'b0;
    req_a = 1'b1;
    req_b = 1'b1;
    lock  = 1'b0;

    // Reset held for two edges with both requests high
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", outs(), O_IDLE_S0);
    check("reset_state", {2'b00, dbg_state}, 4'd0);
    rst_n = 1'b1;

    // Contested burst: A first after reset, then 4/4 alternation
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) step("burst_a", 1'b1, 1'b1, O_A);
      for (int i = 0; i < 4; i++) step("burst_b", 1'b1, 1'b1, O_B);
    end

    // Release to IDLE: s holds its last value
    step("idle_hold_s1", 1'b0, 1'b0, O_IDLE_S1);

    // Early release at count 1 with B waiting: direct switch
    step("early_a0", 1'b1, 1'b0, O_A);
    step("early_a1", 1'b1, 1'b0, O_A);
    step("early_sw_b", 1'b0, 1'b1, O_B);

    // Single requester B: no drop at hold expiry
    for (int i = 0; i < 10; i++) step("single_b", 1'b0, 1'b1, O_B);

    // Asynchronous reset between edges while in GNT_B
    rst_n = 1'b0;
    #1;
    check("async_rst", outs(), O_IDLE_S0);
    #2;
    rst_n = 1'b1;
    step("post_rst_a", 1'b1, 1'b1, O_A);

    // Idle with s=0, then both request with last-served A: B wins
    step("idle_hold_s0", 1'b0, 1'b0, O_IDLE_S0);
    step("rr_to_b", 1'b1, 1'b1, O_B);
    step("idle_after_b", 1'b0, 1'b0, O_IDLE_S1);

    // Randomised single-request pulses from IDLE: 1-cycle latency, then back to IDLE
    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        step("rand_a", 1'b1, 1'b0, O_A);
        step("rand_a_rel", 1'b0, 1'b0, O_IDLE_S0);
      end else begin
        step("rand_b", 1'b0, 1'b1, O_B);
        step("rand_b_rel", 1'b0, 1'b0, O_IDLE_S1);
      end
    end

`ifdef SEL_LOCK_EN
    // Lock pins GNT_A past hold expiry; releasing lock switches at the next edge
    step("lock_pre_idle", 1'b0, 1'b0, outs());
    // Force last-served to B so that A wins the contested entry
    step("lock_b", 1'b0, 1'b1, O_B);
    step("lock_idle", 1'b0, 1'b0, O_IDLE_S1);
    lock = 1'b1;
    for (int i = 0; i < 12; i++) step("lock_hold_a", 1'b1, 1'b1, O_A);
    lock = 1'b0;
    step("lock_release_b", 1'b1, 1'b1, O_B);
    lock = 1'b1;
    step("lock_drop_req", 1'b1, 1'b0, O_A);
    lock = 1'b0;
`endif

    if (exp_q.size() != 0) check("queue_drained", 4'(exp_q.size()), 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
